ex_alu_md: RTL and testbench

EX_ALU_MD -- requirements
Module: ex_alu_md

---
 rtl/ex_alu_md_if.sv | 33 +++
 rtl/ex_alu_md.sv | 219 +++++++++++++++++++++
 tb/tb_ex_alu_md.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_md_if.sv
// Issue/result bundle between the execute-stage controller and the ALU with
// iterative multiply/divide.
interface ex_alu_md_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic [W-1:0] imm;
  logic         alu_src;
  logic [1:0]   fwd_a;
  logic [1:0]   fwd_b;
  logic [W-1:0] fwd_mem;
  logic [W-1:0] fwd_wb;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, op, rs_data, rt_data, imm, alu_src, fwd_a, fwd_b, fwd_mem, fwd_wb,
    input  in_ready, out_valid, result, result_hi, zero, overflow, busy
  );

  modport slave (
    input  in_valid, op, rs_data, rt_data, imm, alu_src, fwd_a, fwd_b, fwd_mem, fwd_wb,
    output in_ready, out_valid, result, result_hi, zero, overflow, busy
  );
endinterface

// File: rtl/ex_alu_md.sv
// Execute-stage ALU with operand forwarding, single-cycle logic/arith/shift ops and
// iterative unsigned shift-add multiply and restoring divide.
module ex_alu_md #(
  parameter int unsigned W = 32
) (
  input logic       clk,
  input logic       rst,
  ex_alu_md_if.slave bus
);

  localparam int unsigned SHW  = $clog2(W);
  localparam int unsigned CntW = SHW + 1;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpMul  = 4'b0100;
  localparam logic [3:0] OpDiv  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSll  = 4'b1001;
  localparam logic [3:0] OpSrl  = 4'b1010;
  localparam logic [3:0] OpSra  = 4'b1011;
  localparam logic [3:0] OpNor  = 4'b1100;
  localparam logic [3:0] OpSlt  = 4'b1110;
  localparam logic [3:0] OpSltu = 4'b1111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    opnd_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    result_q;
  logic [W-1:0]    result_hi_q;
  logic            zero_q;
  logic            overflow_q;
  logic            out_valid_q;

  logic            idle;
  logic            accept;
  logic            last_iter;
  logic [W-1:0]    a_opnd;
  logic [W-1:0]    b_opnd;
  logic [SHW-1:0]  shamt;
  logic [W-1:0]    sum;
  logic [W-1:0]    diff;
  logic [W-1:0]    alu_res;
  logic            alu_ovf;
  logic            div_by_zero;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_shift;
  logic [W-1:0]    div_rem;
  logic            div_ge;
  logic [2*W-1:0]  div_next;
  logic [2*W-1:0]  acc_next;

  // Operand selection; code 11 falls back to the register/immediate path.
  always_comb begin
    a_opnd = bus.rs_data;
    unique case (bus.fwd_a)
      2'b01:   a_opnd = bus.fwd_wb;
      2'b10:   a_opnd = bus.fwd_mem;
      default: a_opnd = bus.rs_data;
    endcase
  end

  always_comb begin
    b_opnd = bus.rt_data;
    unique case (bus.fwd_b)
      2'b01:   b_opnd = bus.fwd_wb;
      2'b10:   b_opnd = bus.fwd_mem;
      default: b_opnd = bus.alu_src ? bus.imm : bus.rt_data;
    endcase
  end

  assign shamt       = a_opnd[SHW-1:0];
  assign sum         = a_opnd + b_opnd;
  assign diff        = a_opnd - b_opnd;
  assign div_by_zero = (b_opnd == '0);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OpAnd:  alu_res = a_opnd & b_opnd;
      OpOr:   alu_res = a_opnd | b_opnd;
      OpXor:  alu_res = a_opnd ^ b_opnd;
      OpNor:  alu_res = ~(a_opnd | b_opnd);
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (a_opnd[W-1] == b_opnd[W-1]) && (sum[W-1] != a_opnd[W-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (a_opnd[W-1] != b_opnd[W-1]) && (diff[W-1] != a_opnd[W-1]);
      end
      OpSlt:  alu_res = {{(W-1){1'b0}}, ($signed(a_opnd) < $signed(b_opnd))};
      OpSltu: alu_res = {{(W-1){1'b0}}, (a_opnd < b_opnd)};
      OpSll:  alu_res = b_opnd << shamt;
      OpSrl:  alu_res = b_opnd >> shamt;
      OpSra:  alu_res = W'($signed(b_opnd) >>> shamt);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Multiply: acc holds {partial product, remaining multiplier}; the extra carry bit
  // of the add is shifted into the top on each step.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

  // Divide: acc holds {partial remainder, dividend/quotient bits}.
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_rem   = div_shift[W-1:0] - opnd_q;
  assign div_next  = div_ge ? {div_rem, acc_q[W-2:0], 1'b1}
                            : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};

  assign acc_next  = (state_q == StMul) ? mul_next : div_next;
  assign last_iter = (cnt_q == CntW'(1));
  assign accept    = bus.in_valid & idle;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && bus.op == OpMul) begin
          state_d = StMul;
        end else if (accept && bus.op == OpDiv && !div_by_zero) begin
          state_d = StDiv;
        end
      end
      StMul, StDiv: begin
        if (last_iter) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    idle     = (state_q == StIdle);
    bus.busy = (state_q != StIdle);
  end

  assign bus.in_ready = idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        if (bus.op == OpMul) begin
          opnd_q <= a_opnd;
          acc_q  <= {{W{1'b0}}, b_opnd};
          cnt_q  <= CntW'(W);
        end else if (bus.op == OpDiv && !div_by_zero) begin
          opnd_q <= b_opnd;
          acc_q  <= {{W{1'b0}}, a_opnd};
          cnt_q  <= CntW'(W);
        end else if (bus.op == OpDiv) begin
          result_q    <= '1;
          result_hi_q <= a_opnd;
          zero_q      <= 1'b0;
          overflow_q  <= 1'b0;
          out_valid_q <= 1'b1;
        end else begin
          result_q    <= alu_res;
          result_hi_q <= '0;
          zero_q      <= (alu_res == '0);
          overflow_q  <= alu_ovf;
          out_valid_q <= 1'b1;
        end
      end else if (!idle) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q - CntW'(1);
        if (last_iter) begin
          result_q    <= acc_next[W-1:0];
          result_hi_q <= acc_next[2*W-1:W];
          zero_q      <= (acc_next[W-1:0] == '0);
          overflow_q  <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ex_alu_md.sv
// Directed bench for ex_alu_md: a 32-bit instance for the main vectors and an
// 8-bit instance for the narrow-width multiply and compare cases.
module tb_ex_alu_md;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   rdy_low;
  int   pulses;

  ex_alu_md_if #(.W(32)) b32 ();
  ex_alu_md_if #(.W(8))  b8 ();

  ex_alu_md #(.W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
  ex_alu_md #(.W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one op on the 32-bit port, hold it over one rising edge, then withdraw.
  task automatic issue32(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src, input logic [1:0] fa,
                         input logic [1:0] fb, input logic [31:0] fm, input logic [31:0] fw);
    b32.op       = op;
    b32.rs_data  = rs;
    b32.rt_data  = rt;
    b32.imm      = imm;
    b32.alu_src  = src;
    b32.fwd_a    = fa;
    b32.fwd_b    = fb;
    b32.fwd_mem  = fm;
    b32.fwd_wb   = fw;
    b32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] rs, input logic [7:0] rt);
    b8.op       = op;
    b8.rs_data  = rs;
    b8.rt_data  = rt;
    b8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts edges until out_valid and the number of
  // sampled cycles with in_ready low. An expired bound returns max+1.
  task automatic wait_out(input bit narrow, input int max, output int cycles, output int lows);
    cycles = max + 1;
    lows   = 0;
    for (int i = 1; i <= max; i++) begin
      if (!(narrow ? b8.in_ready : b32.in_ready)) lows++;
      @(posedge clk);
      #1;
      if (narrow ? b8.out_valid : b32.out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    b32.in_valid = 1'b0; b32.op = '0; b32.rs_data = '0; b32.rt_data = '0; b32.imm = '0;
    b32.alu_src = 1'b0; b32.fwd_a = '0; b32.fwd_b = '0; b32.fwd_mem = '0; b32.fwd_wb = '0;
    b8.in_valid = 1'b0; b8.op = '0; b8.rs_data = '0; b8.rt_data = '0; b8.imm = '0;
    b8.alu_src = 1'b0; b8.fwd_a = '0; b8.fwd_b = '0; b8.fwd_mem = '0; b8.fwd_wb = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", b32.out_valid, 0);
    check("rst result", b32.result, 0);
    check("rst result_hi", b32.result_hi, 0);
    check("rst zero", b32.zero, 0);
    check("rst overflow", b32.overflow, 0);
    check("rst busy", b32.busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-rst in_ready", b32.in_ready, 1);

    // Signed overflow on ADD.
    issue32(4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0);
    check("add out_valid", b32.out_valid, 1);
    check("add result", b32.result, 32'h8000_0000);
    check("add overflow", b32.overflow, 1);
    check("add zero", b32.zero, 0);
    @(posedge clk);
    #1;
    check("add pulse ends", b32.out_valid, 0);
    check("add result held", b32.result, 32'h8000_0000);

    // SUB with fwd_mem on B, then back-to-back SRA.
    issue32(4'b0110, 32'd5, 32'd99, 0, 0, 2'b00, 2'b10, 32'd5, 0);
    check("sub result", b32.result, 0);
    check("sub zero", b32.zero, 1);
    check("sub overflow", b32.overflow, 0);
    issue32(4'b1011, 32'd4, 32'h8000_0000, 0, 0, 2'b00, 2'b00, 0, 0);
    check("sra out_valid", b32.out_valid, 1);
    check("sra result", b32.result, 32'hF800_0000);
    check("sra zero", b32.zero, 0);

    issue32(4'b0001, 32'hF0, 32'hFF00, 32'h0F, 1, 2'b00, 2'b00, 0, 0);
    check("or imm", b32.result, 32'hFF);
    issue32(4'b0000, 32'h1234, 32'h00FF, 0, 0, 2'b01, 2'b00, 0, 32'h0FF0);
    check("and fwd_wb", b32.result, 32'hF0);
    issue32(4'b0011, 32'hAAAA, 32'h5555, 32'h1, 1, 2'b11, 2'b11, 32'h7, 32'h7);
    check("xor fwd 11", b32.result, 32'hAAAB);
    issue32(4'b1100, 32'hFFFF_0000, 32'h0000_00FF, 0, 0, 2'b00, 2'b00, 0, 0);
    check("nor", b32.result, 32'h0000_FF00);
    issue32(4'b1001, 32'd36, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0);
    check("sll mod amount", b32.result, 32'h10);
    issue32(4'b1010, 32'd4, 32'h8000_0000, 0, 0, 2'b00, 2'b00, 0, 0);
    check("srl", b32.result, 32'h0800_0000);
    issue32(4'b1110, 32'hFFFF_FFFF, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0);
    check("slt32", b32.result, 1);
    issue32(4'b1111, 32'hFFFF_FFFF, 32'h1, 0, 0, 2'b00, 2'b00, 0, 0);
    check("sltu32", b32.result, 0);
    issue32(4'b0111, 32'h5, 32'h3, 0, 0, 2'b00, 2'b00, 0, 0);
    check("undef result", b32.result, 0);
    check("undef zero", b32.zero, 1);

    // MUL, with an ignored request held during the busy period.
    issue32(4'b0100, 32'hFFFF_FFFF, 32'd2, 0, 0, 2'b00, 2'b00, 0, 0);
    check("mul busy", b32.busy, 1);
    check("mul in_ready", b32.in_ready, 0);
    b32.op = 4'b0010; b32.rs_data = 32'h7FFF_FFFF; b32.rt_data = 32'h1;
    b32.in_valid = 1'b1;
    wait_out(0, 40, cyc, rdy_low);
    b32.in_valid = 1'b0;
    check("mul latency", cyc, 32);
    check("mul ready low", rdy_low, 32);
    check("mul result", b32.result, 32'hFFFF_FFFE);
    check("mul result_hi", b32.result_hi, 1);
    check("mul overflow", b32.overflow, 0);
    @(posedge clk);
    #1;
    check("busy req ignored", b32.out_valid, 0);

    issue32(4'b0101, 32'd100, 32'd7, 0, 0, 2'b00, 2'b00, 0, 0);
    wait_out(0, 40, cyc, rdy_low);
    check("div latency", cyc, 32);
    check("div quotient", b32.result, 14);
    check("div remainder", b32.result_hi, 2);

    issue32(4'b0101, 32'd9, 32'd0, 0, 0, 2'b00, 2'b00, 0, 0);
    check("div0 out_valid", b32.out_valid, 1);
    check("div0 result", b32.result, 32'hFFFF_FFFF);
    check("div0 result_hi", b32.result_hi, 9);
    check("div0 busy", b32.busy, 0);

    // Reset in the middle of a multiply.
    issue32(4'b0100, 32'd3, 32'd5, 0, 0, 2'b00, 2'b00, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort result", b32.result, 0);
    check("abort result_hi", b32.result_hi, 0);
    check("abort out_valid", b32.out_valid, 0);
    check("abort busy", b32.busy, 0);
    check("abort in_ready", b32.in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (b32.out_valid) pulses++;
    end
    check("abort no pulse", pulses, 0);
    issue32(4'b0010, 32'd2, 32'd3, 0, 0, 2'b00, 2'b00, 0, 0);
    check("add after abort", b32.result, 5);

    // Narrow instance.
    issue8(4'b0100, 8'hFF, 8'hFF);
    wait_out(1, 20, cyc, rdy_low);
    check("mul8 latency", cyc, 8);
    check("mul8 result", b8.result, 8'h01);
    check("mul8 result_hi", b8.result_hi, 8'hFE);
    issue8(4'b1110, 8'h80, 8'h01);
    check("slt8", b8.result, 1);
    issue8(4'b1111, 8'h80, 8'h01);
    check("sltu8", b8.result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
